// File: rtl/load_store_unit_if.sv
// Request/response handshake and memory data-port bundle for load_store_unit.
// master: core and memory side; slave: the load/store unit itself.
interface load_store_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned DATA_INDEXING_WIDTH = $clog2(DATA_WIDTH / 8);

  logic                         req_valid;
  logic                         req_ready;
  logic                         req_is_store;
  logic [1:0]                   req_size;
  logic                         req_unsigned;
  logic [ADDR_WIDTH-1:0]        req_addr;
  logic [DATA_WIDTH-1:0]        req_wdata;
  logic                         resp_valid;
  logic                         resp_ready;
  logic [DATA_WIDTH-1:0]        resp_rdata;
  logic                         resp_error;
  logic [ADDR_WIDTH-1:0]        fetch_addr;
  logic [DATA_WIDTH-1:0]        fetched_data;
  logic                         fetch_done;
  logic [ADDR_WIDTH-1:0]        write_addr;
  logic [DATA_WIDTH-1:0]        write_data;
  logic [DATA_INDEXING_WIDTH:0] bytes_to_write;
  logic                         write_activate;
  logic                         write_done;

  modport master (
    output req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
           fetched_data, fetch_done, write_done,
    input  req_ready, resp_valid, resp_rdata, resp_error, fetch_addr, write_addr, write_data,
           bytes_to_write, write_activate
  );

  modport slave (
    input  req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
           fetched_data, fetch_done, write_done,
    output req_ready, resp_valid, resp_rdata, resp_error, fetch_addr, write_addr, write_data,
           bytes_to_write, write_activate
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between execute and the byte-addressed memory data port.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses without touching memory.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);
  localparam int unsigned DATA_INDEXING_WIDTH = $clog2(DATA_WIDTH / 8);
  localparam int unsigned BytesW              = DATA_INDEXING_WIDTH + 1;
  localparam int unsigned CntW                = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StLoad, StStore, StResp} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic                    misaligned;
  logic                    expired;
  logic [DATA_WIDTH-1:0]   load_ext;
  logic [DATA_WIDTH-1:0]   store_data;
  logic [BytesW-1:0]       store_bytes;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                      ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Last waiting cycle: counter would reach TIMEOUT_CYCLES-1 on this edge.
  assign expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 2));

  always_comb begin
    load_ext = bus.fetched_data;
    case (size_q)
      2'd0:    load_ext = {{(DATA_WIDTH - 8){~uns_q & bus.fetched_data[7]}},
                           bus.fetched_data[7:0]};
      2'd1:    load_ext = {{(DATA_WIDTH - 16){~uns_q & bus.fetched_data[15]}},
                           bus.fetched_data[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    store_data  = '0;
    store_bytes = BytesW'(4);
    case (size_q)
      2'd0: begin
        store_data[7:0] = wdata_q[7:0];
        store_bytes     = BytesW'(1);
      end
      2'd1: begin
        store_data[15:0] = wdata_q[15:0];
        store_bytes      = BytesW'(2);
      end
      default: store_data = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_rdata     = '0;
    bus.resp_error     = 1'b0;
    bus.fetch_addr     = '0;
    bus.write_addr     = '0;
    bus.write_data     = '0;
    bus.bytes_to_write = '0;
    bus.write_activate = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          if ((bus.req_size == 2'd3) || misaligned) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = bus.req_is_store ? StStore : StLoad;
          end
        end
      end
      StLoad: begin
        bus.fetch_addr = addr_q;
        cnt_d          = cnt_q + CntW'(1);
        if (bus.fetch_done) begin
          rdata_d = load_ext;
          state_d = StResp;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StStore: begin
        // Gated by rst so a reset edge can never coincide with a committing write.
        bus.write_activate = ~rst;
        bus.write_addr     = addr_q;
        bus.write_data     = store_data;
        bus.bytes_to_write = store_bytes;
        cnt_d              = cnt_q + CntW'(1);
        if (bus.write_done) begin
          state_d = StResp;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata_q;
        bus.resp_error = err_q;
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, corner sequences and
// randomized requests against a byte-array reference model.
module tb_load_store_unit;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  load_store_unit #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Physical memory (written only through the DUT) and the reference image; 4 KiB, wrapping.
  logic [7:0]  mem     [4096];
  logic [7:0]  ref_mem [4096];
  logic        mem_clr;
  logic        wd_block;
  logic        fd_block;
  int unsigned wd_delay;
  int unsigned wa_run       = 0;
  int unsigned wr_count     = 0;
  int unsigned wa_cycles    = 0;
  int unsigned fetch_cycles = 0;
  logic [31:0] last_waddr   = '0;
  logic [31:0] last_wdata   = '0;
  logic [2:0]  last_bytes   = '0;
  int          errors       = 0;
  int          checks       = 0;

  assign bus.fetch_done   = ~fd_block;
  assign bus.write_done   = bus.write_activate && !wd_block && (wa_run >= wd_delay);
  assign bus.fetched_data = {mem[bus.fetch_addr[11:0] + 12'd3], mem[bus.fetch_addr[11:0] + 12'd2],
                             mem[bus.fetch_addr[11:0] + 12'd1], mem[bus.fetch_addr[11:0]]};

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (bus.write_activate && bus.write_done) begin
      for (int i = 0; i < 4; i++)
        if (i < int'(bus.bytes_to_write))
          mem[bus.write_addr[11:0] + 12'(i)] <= bus.write_data[8*i +: 8];
      wr_count   <= wr_count + 1;
      last_waddr <= bus.write_addr;
      last_wdata <= bus.write_data;
      last_bytes <= bus.bytes_to_write;
    end
    if (bus.write_activate) wa_cycles <= wa_cycles + 1;
    if (bus.fetch_addr != '0) fetch_cycles <= fetch_cycles + 1;
    wa_run <= (bus.write_activate && !bus.write_done) ? wa_run + 1 : 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
    return Trap && (((sz == 2'd1) && (a % 2 != 0)) || ((sz == 2'd2) && (a % 4 != 0)));
  endfunction

  function automatic int unsigned ref_nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic un,
                                           input logic [31:0] a);
    longint v = 0;
    int unsigned n = ref_nbytes(sz);
    for (int i = 0; i < int'(n); i++) v += longint'(ref_mem[12'(a + 32'(i))]) << (8 * i);
    if (n < 4 && !un && v >= (64'sd1 << (8 * n - 1))) v -= (64'sd1 << (8 * n));
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_store_data(input logic [1:0] sz, input logic [31:0] wd);
    return (sz == 2'd2) ? wd : 32'(wd % (32'd1 << (8 * ref_nbytes(sz))));
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < int'(ref_nbytes(sz)); i++) ref_mem[12'(a + 32'(i))] = wd[8*i +: 8];
  endtask

  task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    int n = 0;
    int unsigned wa0, fc0;
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_size     = sz;
    bus.req_unsigned = un;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    while (!bus.req_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    lat = 1;
    while (!bus.resp_valid && lat < int'(3 * TO)) begin
      @(negedge clk);
      lat++;
    end
    check("resp_seen", 32'(bus.resp_valid), 32'd1);
    rd  = bus.resp_rdata;
    er  = bus.resp_error;
    wa0 = wa_cycles;
    fc0 = fetch_cycles;
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = $urandom;
      bus.req_size  = 2'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(bus.resp_valid), 32'd1);
      check("hold_rdata", bus.resp_rdata, rd);
      check("hold_error", 32'(bus.resp_error), 32'(er));
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    if (hold > 0) check("hold_mem_idle", (wa_cycles - wa0) + (fetch_cycles - fc0), 32'd0);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("resp_release", 32'(bus.resp_valid), 32'd0);
  endtask

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic [1:0] sz, input logic un, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input logic er, input int lat);
    vec_t v;
    v.st = st; v.sz = sz; v.un = un; v.addr = a; v.wd = wd;
    v.exp_rd = rd; v.exp_err = er; v.exp_lat = lat;
    vecs.push_back(v);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int unsigned wc0, wa0, fc0, mism;
    logic [1:0]  sz;
    logic        st, un, exp_err;
    logic [31:0] a, wd, exp_rd;

    rst = 1'b1; mem_clr = 1'b1; wd_block = 1'b0; fd_block = 1'b0; wd_delay = 0;
    bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    mem_clr = 1'b0;

    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_error", 32'(bus.resp_error), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_write_activate", 32'(bus.write_activate), 32'd0);
    check("rst_bytes_to_write", 32'(bus.bytes_to_write), 32'd0);
    check("rst_ports_addr_data", bus.fetch_addr | bus.write_addr | bus.write_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // {store, size, unsigned, addr, wdata, expected rdata, expected error, expected latency}
    add(1, 2, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2);
    add(0, 2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2);
    add(1, 2, 0, 32'h104, 32'h11223344, 32'h0, 0, 2);
    add(1, 0, 0, 32'h104, 32'hAAAAAA80, 32'h0, 0, 2);
    add(0, 0, 0, 32'h104, 32'h0, 32'hFFFFFF80, 0, 2);
    add(0, 0, 1, 32'h104, 32'h0, 32'h00000080, 0, 2);
    add(0, 2, 0, 32'h104, 32'h0, 32'h11223380, 0, 2);
    add(0, 3, 0, 32'h200, 32'h0, 32'h0, 1, 1);
    add(1, 3, 0, 32'h208, 32'h12345678, 32'h0, 1, 1);
    add(1, 1, 0, 32'h108, 32'h1234F00D, 32'h0, 0, 2);
    add(0, 1, 0, 32'h108, 32'h0, 32'hFFFFF00D, 0, 2);
    add(0, 1, 1, 32'h108, 32'h0, 32'h0000F00D, 0, 2);
    add(0, 1, 0, 32'h101, 32'h0, Trap ? 32'h0 : 32'hFFFFADBE, Trap, Trap ? 1 : 2);
    add(0, 2, 0, 32'h102, 32'h0, Trap ? 32'h0 : 32'h3380DEAD, Trap, Trap ? 1 : 2);
    add(1, 1, 0, 32'h10B, 32'h0000CAFE, 32'h0, Trap, Trap ? 1 : 2);
    add(0, 0, 1, 32'h10B, 32'h0, Trap ? 32'h0 : 32'h000000FE, 0, 2);
    add(0, 2, 1, 32'h108, 32'h0, Trap ? 32'h0000F00D : 32'hFE00F00D, 0, 2);
    add(0, 0, 0, 32'h109, 32'h0, 32'hFFFFFFF0, 0, 2);
    add(0, 1, 1, 32'h100, 32'h0, 32'h0000BEEF, 0, 2);
    add(1, 0, 0, 32'hFFFFFFFF, 32'h0000005A, 32'h0, 0, 2);
    add(0, 0, 1, 32'hFFFFFFFF, 32'h0, 32'h0000005A, 0, 2);

    foreach (vecs[k]) begin
      wc0 = wr_count;
      do_req(vecs[k].st, vecs[k].sz, vecs[k].un, vecs[k].addr, vecs[k].wd, k % 3, rd, er, lat);
      check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rd);
      check($sformatf("vec%0d_error", k), 32'(er), 32'(vecs[k].exp_err));
      check($sformatf("vec%0d_latency", k), 32'(lat), 32'(vecs[k].exp_lat));
      if (vecs[k].st && !vecs[k].exp_err) begin
        check($sformatf("vec%0d_writes", k), wr_count - wc0, 32'd1);
        check($sformatf("vec%0d_waddr", k), last_waddr, vecs[k].addr);
        check($sformatf("vec%0d_bytes", k), 32'(last_bytes), ref_nbytes(vecs[k].sz));
        check($sformatf("vec%0d_wdata", k), last_wdata, ref_store_data(vecs[k].sz, vecs[k].wd));
        ref_store(vecs[k].sz, vecs[k].addr, vecs[k].wd);
      end else begin
        check($sformatf("vec%0d_writes", k), wr_count - wc0, 32'd0);
      end
    end

    // Store that never completes: watchdog error, no write.
    wd_block = 1'b1;
    wc0 = wr_count; wa0 = wa_cycles;
    do_req(1, 2, 0, 32'h400, 32'h55AA55AA, 0, rd, er, lat);
    check("st_timeout_error", 32'(er), 32'd1);
    check("st_timeout_rdata", rd, 32'd0);
    check("st_timeout_latency", 32'(lat), TO);
    check("st_timeout_wa_cycles", wa_cycles - wa0, TO - 1);
    check("st_timeout_writes", wr_count - wc0, 32'd0);
    check("st_timeout_mem", 32'(mem[12'h400]), 32'd0);
    wd_block = 1'b0;

    // Load that never completes.
    fd_block = 1'b1;
    do_req(0, 2, 0, 32'h100, 32'h0, 0, rd, er, lat);
    check("ld_timeout_error", 32'(er), 32'd1);
    check("ld_timeout_rdata", rd, 32'd0);
    check("ld_timeout_latency", 32'(lat), TO);
    fd_block = 1'b0;

    // Illegal size and misaligned half: memory port activity.
    wa0 = wa_cycles; fc0 = fetch_cycles;
    do_req(0, 3, 0, 32'h120, 32'h0, 0, rd, er, lat);
    check("illegal_mem_idle", (wa_cycles - wa0) + (fetch_cycles - fc0), 32'd0);
    fc0 = fetch_cycles;
    do_req(0, 1, 0, 32'h101, 32'h0, 0, rd, er, lat);
    check("misalign_fetch_cycles", fetch_cycles - fc0, Trap ? 32'd0 : 32'd1);

    // Response held off for 5 cycles with a competing request pending.
    do_req(0, 2, 0, 32'h100, 32'h0, 5, rd, er, lat);
    check("hold_load_rdata", rd, 32'hDEADBEEF);

    // Reset in the middle of a stalled store.
    wd_block = 1'b1;
    wc0 = wr_count;
    bus.req_valid = 1'b1; bus.req_is_store = 1'b1; bus.req_size = 2'd2;
    bus.req_addr = 32'h500; bus.req_wdata = 32'h12345678;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midst_write_activate", 32'(bus.write_activate), 32'd1);
    rst = 1'b1;
    wd_block = 1'b0;
    #1;
    check("midst_rst_wa_now", 32'(bus.write_activate), 32'd0);
    @(negedge clk);
    check("midst_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("midst_rst_wa_next", 32'(bus.write_activate), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midst_rst_no_resp", 32'(bus.resp_valid), 32'd0);
    check("midst_rst_writes", wr_count - wc0, 32'd0);
    check("midst_rst_mem", {mem[12'h503], mem[12'h502], mem[12'h501], mem[12'h500]}, 32'd0);

    // Randomized traffic against the reference image.
    for (int it = 0; it < 200; it++) begin
      st = 1'($urandom);
      sz = 2'($urandom);
      un = 1'($urandom);
      wd = $urandom;
      a  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0 + $urandom_range(0, 15)
                                       : 32'h300 + $urandom_range(0, 63);
      wd_delay = $urandom_range(0, 4);
      exp_err  = (sz == 2'd3) || ref_misaligned(sz, a);
      exp_rd   = (!exp_err && !st) ? ref_load(sz, un, a) : 32'h0;
      wc0 = wr_count;
      do_req(st, sz, un, a, wd, $urandom_range(0, 2), rd, er, lat);
      check($sformatf("rnd%0d_rdata", it), rd, exp_rd);
      check($sformatf("rnd%0d_error", it), 32'(er), 32'(exp_err));
      check($sformatf("rnd%0d_latency", it), 32'(lat),
            exp_err ? 32'd1 : (st ? 32'(2 + wd_delay) : 32'd2));
      check($sformatf("rnd%0d_writes", it), wr_count - wc0, (st && !exp_err) ? 32'd1 : 32'd0);
      if (st && !exp_err) ref_store(sz, a, wd);
    end
    wd_delay = 0;

    mism = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("mem_image_mismatches", mism, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
